// File: rtl/bram_stream_reader.sv
// bram_stream_reader
//   Streams a run of consecutive words out of a dual-port BRAM. Both BRAM
//   ports are used as read ports, so up to two words are fetched per clock.
//   The read data goes into a small output FIFO, and the FIFO head is
//   presented on a valid/ready stream.
//
// Ports
//   clk            : single clock, rising edge
//   reset          : asynchronous, active-low
//   start          : one-cycle request, only honoured while idle
//   base_addr      : address of the first word (captured with start)
//   length         : number of words, 0..2^ADDR_W (captured with start)
//   addr_a/addr_b  : registered BRAM read addresses
//   we_a/we_b      : BRAM write enables, tied low
//   q_a/q_b        : BRAM read data, one edge after the address
//   out_data       : FIFO head
//   out_valid      : out_data holds a word
//   out_ready      : consumer accepts the word
//   busy           : transfer in progress (every state except IDLE)
//   done           : one-cycle pulse when the transfer completes
module bram_stream_reader #(
  parameter int DATA_W     = 48,
  parameter int ADDR_W     = 10,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   length,
  output logic [ADDR_W-1:0] addr_a,
  output logic [ADDR_W-1:0] addr_b,
  output logic              we_a,
  output logic              we_b,
  input  logic [DATA_W-1:0] q_a,
  input  logic [DATA_W-1:0] q_b,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nx;

  logic [ADDR_W-1:0]   r_base;
  logic [ADDR_W:0]     r_len;
  logic [ADDR_W:0]     r_off;
  logic [ADDR_W-1:0]   r_addr_a;
  logic [ADDR_W-1:0]   r_addr_b;

  // Bit 0 tracks the port A word, bit 1 the port B word of an issued pair.
  logic [1:0]          r_vld_p0;
  logic [1:0]          r_vld_p1;

  logic [DATA_W-1:0]   r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wptr;
  logic [PTR_W-1:0]    r_rptr;
  logic [CNT_W-1:0]    r_count;

  logic [ADDR_W:0]     w_remain;
  logic [ADDR_W-1:0]   w_addr_a;
  logic [ADDR_W-1:0]   w_addr_b;
  logic [ADDR_W:0]     w_step;
  logic [CNT_W-1:0]    w_inflight;
  logic [CNT_W-1:0]    w_push_n;
  logic [PTR_W-1:0]    w_wptr_b;
  logic                w_room;
  logic                w_load;
  logic                w_issue_a;
  logic                w_issue_b;
  logic                w_pop;
  logic                w_pipe_empty;

  assign w_remain   = r_len - r_off;
  assign w_addr_a   = r_base + r_off[ADDR_W-1:0];
  assign w_addr_b   = w_addr_a + ADDR_W'(1);
  assign w_issue_b  = w_issue_a && (w_remain >= (ADDR_W+1)'(2));
  assign w_step     = w_issue_b ? (ADDR_W+1)'(2) : (ADDR_W+1)'(1);
  assign w_load     = (r_state == S_IDLE) && start;

  assign w_inflight = CNT_W'(r_vld_p0[0]) + CNT_W'(r_vld_p0[1])
                    + CNT_W'(r_vld_p1[0]) + CNT_W'(r_vld_p1[1]);
  assign w_push_n   = CNT_W'(r_vld_p1[0]) + CNT_W'(r_vld_p1[1]);
  assign w_wptr_b   = r_wptr + PTR_W'(1);
  assign w_pipe_empty = (r_vld_p0 == 2'b00) && (r_vld_p1 == 2'b00);

  // Credit check ignores a concurrent pop, so every word in flight is
  // guaranteed a FIFO slot when it lands two edges later.
  assign w_room = ((CNT_W+1)'(r_count) + (CNT_W+1)'(w_inflight) + (CNT_W+1)'(2))
                  <= (CNT_W+1)'(FIFO_DEPTH);

  assign out_valid = (r_count != '0);
  assign w_pop     = out_valid && out_ready;
  assign out_data  = r_mem[r_rptr];

  assign addr_a = r_addr_a;
  assign addr_b = r_addr_b;
  assign we_a   = 1'b0;
  assign we_b   = 1'b0;
  assign busy   = (r_state != S_IDLE);
  assign done   = (r_state == S_DONE);

  always_comb begin
    w_state_nx = r_state;
    w_issue_a  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nx = (length == '0) ? S_DONE : S_READ;
        end
      end
      S_READ: begin
        if (w_room) begin
          w_issue_a = 1'b1;
          if (w_remain <= (ADDR_W+1)'(2)) begin
            w_state_nx = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        // Leave on the edge that pops the final word, so done follows the
        // last handshake immediately.
        if (w_pipe_empty && ((r_count == '0) ||
            ((r_count == CNT_W'(1)) && w_pop))) begin
          w_state_nx = S_DONE;
        end
      end
      S_DONE: begin
        w_state_nx = S_IDLE;
      end
      default: begin
        w_state_nx = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_base   <= '0;
      r_len    <= '0;
      r_off    <= '0;
      r_addr_a <= '0;
      r_addr_b <= '0;
      r_vld_p0 <= '0;
      r_vld_p1 <= '0;
      r_wptr   <= '0;
      r_rptr   <= '0;
      r_count  <= '0;
    end else begin
      r_state <= w_state_nx;
      if (w_load) begin
        r_base <= base_addr;
        r_len  <= length;
        r_off  <= '0;
      end else if (w_issue_a) begin
        r_addr_a <= w_addr_a;
        r_addr_b <= w_addr_b;
        r_off    <= r_off + w_step;
      end
      // p0: addresses registered this edge, BRAM output after next edge
      r_vld_p0 <= {w_issue_b, w_issue_a};
      // p1: q_a/q_b valid now, written into the FIFO on the next edge
      r_vld_p1 <= r_vld_p0;
      r_wptr   <= r_wptr + w_push_n[PTR_W-1:0];
      r_rptr   <= r_rptr + PTR_W'(w_pop);
      r_count  <= r_count + w_push_n - CNT_W'(w_pop);
    end
  end

  // FIFO storage: A lands before B so output order is ascending address.
  always_ff @(posedge clk) begin
    if (r_vld_p1[0]) begin
      r_mem[r_wptr] <= q_a;
    end
    if (r_vld_p1[1]) begin
      r_mem[w_wptr_b] <= q_b;
    end
  end

endmodule

// File: tb/tb_bram_stream_reader.sv
module tb_bram_stream_reader;

  localparam int DATA_W     = 48;
  localparam int ADDR_W     = 10;
  localparam int FIFO_DEPTH = 8;
  localparam int MAX_CYC    = 6000;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W:0]   length;
  logic [ADDR_W-1:0] addr_a, addr_b;
  logic              we_a, we_b;
  logic [DATA_W-1:0] q_a, q_b;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic              busy;
  logic              done;

  always #5 clk = ~clk;

  bram_stream_reader #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk), .reset(rst_n), .start(start), .base_addr(base_addr),
    .length(length), .addr_a(addr_a), .addr_b(addr_b), .we_a(we_a),
    .we_b(we_b), .q_a(q_a), .q_b(q_b), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done)
  );

  // BRAM model: word i holds value i, read data one edge after the address.
  logic [DATA_W-1:0] bram [1 << ADDR_W];
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) bram[i] = DATA_W'(i);
  end
  always @(posedge clk) begin
    q_a <= bram[addr_a];
    q_b <= bram[addr_b];
  end

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor, sampled on the falling edge. Indices count falling edges.
  int   ncyc = 0;
  int   start_n = -1, first_valid_n = -1, done_n = -1, last_hs_n = -1;
  int   done_cnt = 0, hs_cnt = 0;
  logic stall_prev = 1'b0;
  logic [DATA_W-1:0] prev_data = '0;

  always @(negedge clk) begin
    ncyc++;
    if (rst_n) begin
      chk("we_low", {62'd0, we_a, we_b}, 64'd0);
      if (stall_prev) begin
        chk("stall_valid", 64'(out_valid), 64'd1);
        chk("stall_data", 64'(out_data), 64'(prev_data));
      end
      if (out_valid && first_valid_n < 0) first_valid_n = ncyc;
      if (done) begin
        done_cnt++;
        done_n = ncyc;
      end
      if (out_valid && out_ready) begin
        hs_cnt++;
        last_hs_n = ncyc;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got %0d, expected no word", out_data);
        end else begin
          chk("data", 64'(out_data), 64'(exp_q.pop_front()));
        end
      end
      stall_prev = out_valid && !out_ready;
      prev_data  = out_data;
      if (start && !busy) begin
        start_n = ncyc; first_valid_n = -1; done_n = -1;
        last_hs_n = -1; done_cnt = 0; hs_cnt = 0;
      end
    end else begin
      stall_prev = 1'b0;
    end
  end

  function automatic logic ready_val(input int mode, input int cyc);
    case (mode)
      0:       return 1'b1;
      1:       return 1'($urandom_range(0, 1));
      default: return (cyc >= 20);
    endcase
  endfunction

  task automatic launch(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] l, input int mode);
    for (int k = 0; k < int'(l); k++) exp_q.push_back(DATA_W'((int'(b) + k) % (1 << ADDR_W)));
    @(posedge clk); #1;
    base_addr = b; length = l; start = 1'b1;
    out_ready = (mode == 2) ? 1'b0 : 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // lat: expected falling-edge distance from start seen to first out_valid
  // (start sampled on the next rising edge, valid three rising edges later).
  task automatic finish(input logic [ADDR_W:0] l, input int mode, input int lat);
    int cyc = 0;
    int issued = 0;
    logic [ADDR_W-1:0] pa;
    pa = addr_a;
    while (done_cnt == 0 && cyc < MAX_CYC) begin
      out_ready = ready_val(mode, cyc);
      @(posedge clk); #1;
      cyc++;
      if (mode == 2 && cyc <= 20 && addr_a != pa) issued += 2;
      pa = addr_a;
    end
    if (done_cnt == 0) chk("done_timeout", 64'd0, 64'd1);
    if (mode == 2) chk("stall_buffered", 64'(issued), 64'(FIFO_DEPTH));
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
    end
    chk("done_count", 64'(done_cnt), 64'd1);
    chk("words", 64'(hs_cnt), 64'(l));
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    chk("busy_idle", 64'(busy), 64'd0);
    if (l == '0) begin
      chk("len0_no_valid", 64'(first_valid_n), 64'(-1));
      chk("len0_done_lat", 64'(done_n - start_n), 64'd1);
    end else begin
      chk("done_after_last_hs", 64'(done_n - last_hs_n), 64'd1);
      chk("first_valid_lat", 64'(first_valid_n - start_n), 64'(lat));
    end
    exp_q.delete();
  endtask

  typedef struct {
    logic [ADDR_W-1:0] base;
    logic [ADDR_W:0]   len;
    int                mode;
    int                lat;
  } vec_t;

  vec_t vecs [8];
  logic [ADDR_W-1:0] sa, sb;
  int wait_cyc;

  initial begin
    vecs[0] = '{base: 10'd0,    len: 11'd8,    mode: 0, lat: 4};
    vecs[1] = '{base: 10'd1022, len: 11'd5,    mode: 0, lat: 4};
    vecs[2] = '{base: 10'd5,    len: 11'd1,    mode: 0, lat: 4};
    vecs[3] = '{base: 10'd40,   len: 11'd0,    mode: 0, lat: 0};
    vecs[4] = '{base: 10'd1020, len: 11'd7,    mode: 1, lat: 4};
    vecs[5] = '{base: 10'd300,  len: 11'd13,   mode: 1, lat: 4};
    vecs[6] = '{base: 10'd3,    len: 11'd2,    mode: 0, lat: 4};
    vecs[7] = '{base: 10'd0,    len: 11'd1024, mode: 1, lat: 4};

    rst_n = 1'b0; start = 1'b0; base_addr = '0; length = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_addr_a", 64'(addr_a), 64'd0);
    chk("rst_addr_b", 64'(addr_b), 64'd0);
    rst_n = 1'b1;

    for (int v = 0; v < 8; v++) begin
      launch(vecs[v].base, vecs[v].len, vecs[v].mode);
      finish(vecs[v].len, vecs[v].mode, vecs[v].lat);
    end

    // Zero-length request leaves the BRAM addresses untouched.
    sa = addr_a; sb = addr_b;
    launch(10'd77, 11'd0, 0);
    finish(11'd0, 0, 0);
    chk("len0_addr_a", 64'(addr_a), 64'(sa));
    chk("len0_addr_b", 64'(addr_b), 64'(sb));

    // A second start while busy is ignored.
    launch(10'd200, 11'd6, 0);
    @(posedge clk); #1;
    base_addr = 10'd500; length = 11'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    finish(11'd6, 0, 4);

    // Reset mid-transfer after the third word.
    launch(10'd50, 11'd10, 0);
    wait_cyc = 0;
    while (hs_cnt < 3 && wait_cyc < 100) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    chk("reset_word3_reached", 64'(hs_cnt), 64'd3);
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_addr_a", 64'(addr_a), 64'd0);
    chk("midrst_addr_b", 64'(addr_b), 64'd0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("midrst_no_done", 64'(done_cnt), 64'd0);
    chk("midrst_no_valid", 64'(out_valid), 64'd0);
    launch(10'd50, 11'd10, 0);
    finish(11'd10, 0, 4);

    // Consumer stalled for 20 cycles: FIFO fills to depth, data held stable.
    launch(10'd100, 11'd16, 2);
    finish(11'd16, 2, 4);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
